alu_adder_pipe: RTL and testbench



---
 rtl/alu_adder_pkg.sv | 19 +
 rtl/alu_adder_seg.sv | 24 ++
 rtl/alu_adder_pipe.sv | 150 +++++++++++++++
 tb/tb_alu_adder_pipe.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_adder_pkg.sv
// Shared defaults and per-stage control payload for the pipelined ALU adder.
// Width-dependent payload (operands, partial sum, tag) lives beside this struct in each stage.
package alu_adder_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 4;
    localparam int TAG_W_DEF  = 5;

    // carry: carry-in on the way into a stage, carry-out once registered
    typedef struct packed {
        logic valid;
        logic sub;
        logic sign;
        logic sat;
        logic eq;
        logic carry;
    } stage_ctrl_t;

endpackage

// File: rtl/alu_adder_seg.sv
// One SEG-bit add-with-carry-in segment; B is inverted locally for subtract.
// Equality compares the raw operands so it is independent of the operation.
module alu_adder_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           sub,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           eq
);

    logic [SEG-1:0] xb;
    logic [SEG:0]   full;

    assign xb   = b ^ {SEG{sub}};
    assign full = {1'b0, a} + {1'b0, xb} + {{SEG{1'b0}}, cin};
    assign sum  = full[SEG-1:0];
    assign cout = full[SEG];
    assign eq   = (a == b);

endmodule

// File: rtl/alu_adder_pipe.sv
// Pipelined add/subtract with Z/V/N flags, one carry segment per stage, global stall.
// Optional saturation is enabled by defining ALU_ADDER_SAT_EN (adds the sat port).
module alu_adder_pipe
    import alu_adder_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sign,
`ifdef ALU_ADDER_SAT_EN
    input  logic             sat,
`endif
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    stage_ctrl_t      ctrl_tap [STAGES];
    logic [WIDTH-1:0] a_tap    [STAGES];
    logic [WIDTH-1:0] b_tap    [STAGES];
    logic [WIDTH-1:0] s_tap    [STAGES];
    logic [TAG_W-1:0] tag_tap  [STAGES];

    logic stall;

    assign stall    = ctrl_tap[LAST].valid & ~out_ready;
    assign in_ready = ~stall & ~reset;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            stage_ctrl_t      ctrl_i, ctrl_reg;
            logic [WIDTH-1:0] a_i, b_i, s_i;
            logic [WIDTH-1:0] a_reg, b_reg, s_reg;
            logic [TAG_W-1:0] tag_i, tag_reg;
            logic [SEG-1:0]   seg_sum;
            logic             seg_cout, seg_eq;

            if (gi == 0) begin : g_first
                always_comb begin
                    ctrl_i       = '0;
                    ctrl_i.valid = in_valid;
                    ctrl_i.sub   = sub;
                    ctrl_i.sign  = sign;
`ifdef ALU_ADDER_SAT_EN
                    ctrl_i.sat   = sat;
`endif
                    ctrl_i.eq    = 1'b1;
                    ctrl_i.carry = sub;
                end
                assign a_i   = a;
                assign b_i   = b;
                assign s_i   = '0;
                assign tag_i = tag;
            end else begin : g_next
                assign ctrl_i = ctrl_tap[gi-1];
                assign a_i    = a_tap[gi-1];
                assign b_i    = b_tap[gi-1];
                assign s_i    = s_tap[gi-1];
                assign tag_i  = tag_tap[gi-1];
            end

            alu_adder_seg #(.SEG(SEG)) u_seg (
                .a    (a_i[gi*SEG +: SEG]),
                .b    (b_i[gi*SEG +: SEG]),
                .sub  (ctrl_i.sub),
                .cin  (ctrl_i.carry),
                .sum  (seg_sum),
                .cout (seg_cout),
                .eq   (seg_eq)
            );

            // Bubbles advance like ops; only a downstream stall freezes the whole pipe
            always_ff @(posedge clk) begin
                if (reset) begin
                    ctrl_reg <= '0;
                    a_reg    <= '0;
                    b_reg    <= '0;
                    s_reg    <= '0;
                    tag_reg  <= '0;
                end else if (!stall) begin
                    ctrl_reg       <= ctrl_i;
                    ctrl_reg.eq    <= ctrl_i.eq & seg_eq;
                    ctrl_reg.carry <= seg_cout;
                    a_reg          <= a_i;
                    b_reg          <= b_i;
                    s_reg          <= s_i;
                    s_reg[gi*SEG +: SEG] <= seg_sum;
                    tag_reg        <= tag_i;
                end
            end

            assign ctrl_tap[gi] = ctrl_reg;
            assign a_tap[gi]    = a_reg;
            assign b_tap[gi]    = b_reg;
            assign s_tap[gi]    = s_reg;
            assign tag_tap[gi]  = tag_reg;
        end
    endgenerate

    logic a_msb, xb_msb, s_msb, c_out, v_raw;

    assign a_msb  = a_tap[LAST][WIDTH-1];
    assign xb_msb = b_tap[LAST][WIDTH-1] ^ ctrl_tap[LAST].sub;
    assign s_msb  = s_tap[LAST][WIDTH-1];
    assign c_out  = ctrl_tap[LAST].carry;
    assign v_raw  = (a_msb == xb_msb) & (s_msb != a_msb);

    assign out_valid = ctrl_tap[LAST].valid;
    assign out_tag   = tag_tap[LAST];
    assign z         = ctrl_tap[LAST].eq;
    assign v         = ctrl_tap[LAST].sign & v_raw;
    // Signed: true less-than / exact-result sign; unsigned: borrow or carry-out
    assign n = ctrl_tap[LAST].sign ? (s_msb ^ v_raw)
                                   : (ctrl_tap[LAST].sub ? ~c_out : c_out);

`ifdef ALU_ADDER_SAT_EN
    logic ovf;

    always_comb begin
        ovf = ctrl_tap[LAST].sign ? v_raw : (ctrl_tap[LAST].sub ? ~c_out : c_out);
        s   = s_tap[LAST];
        if (ctrl_tap[LAST].sat && ovf) begin
            if (ctrl_tap[LAST].sign)
                s = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else
                s = ctrl_tap[LAST].sub ? '0 : '1;
        end
    end
`else
    assign s = s_tap[LAST];
`endif

endmodule

// File: tb/tb_alu_adder_pipe.sv
// Self-checking bench for alu_adder_pipe: scoreboard of modelled results plus per-scenario checks.
module tb_alu_adder_pipe;

    localparam int W  = 32;
    localparam int ST = 4;
    localparam int TW = 5;
`ifdef ALU_ADDER_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic          sub, sign, sat;
    logic [TW-1:0] tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          z, v, n;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    alu_adder_pipe #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .sign      (sign),
`ifdef ALU_ADDER_SAT_EN
        .sat       (sat),
`endif
        .tag       (tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .z         (z),
        .v         (v),
        .n         (n),
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [W-1:0]  s;
        logic          z;
        logic          v;
        logic          n;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_got, mon_exp;
    int            checks   = 0;
    int            failures = 0;
    logic [TW-1:0] tag_cnt  = '0;

    // Reference from exact 64-bit arithmetic rather than segment carries
    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic subi, input logic signi, input logic sati,
                                   input logic [TW-1:0] tagi);
        exp_t   e;
        longint sa, sbv, ex, max_p, min_n;
        logic [W:0] ua;
        max_p = 64'sd2147483647;
        min_n = -max_p - 64'sd1;
        sa    = longint'($signed(ai));
        sbv   = longint'($signed(bi));
        ex    = subi ? sa - sbv : sa + sbv;
        ua    = {1'b0, ai} + {1'b0, bi};
        e.s   = subi ? ai - bi : ai + bi;
        e.z   = (ai == bi);
        e.v   = signi && (ex > max_p || ex < min_n);
        e.n   = signi ? (ex < 0) : (subi ? (ai < bi) : ua[W]);
        if (sati) begin
            if (signi) begin
                if (e.v) e.s = (ex > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            end else if (subi) begin
                if (ai < bi) e.s = '0;
            end else if (ua[W]) begin
                e.s = '1;
            end
        end
        e.tag = tagi;
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_valid && out_ready && !reset) begin
            mon_got = {s, z, v, n, out_tag};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got s=%h tag=%0d required no output", s, out_tag);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL result got s=%h z=%b v=%b n=%b tag=%0d required s=%h z=%b v=%b n=%b tag=%0d",
                             mon_got.s, mon_got.z, mon_got.v, mon_got.n, mon_got.tag,
                             mon_exp.s, mon_exp.z, mon_exp.v, mon_exp.n, mon_exp.tag);
                end else begin
                    $display("  result tag=%0d s=%h z=%b v=%b n=%b", out_tag, s, z, v, n);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Starts and returns just after a rising edge; blocks until accepted
    task automatic send_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                           input logic subi, input logic signi, input logic sati);
        int waitc = 0;
        bit done  = 0;
        a = ai; b = bi; sub = subi; sign = signi; sat = sati; tag = tag_cnt;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(ai, bi, subi, signi, sati & SAT_BUILD, tag_cnt));
                done = 1;
            end else if (++waitc > 100) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout got in_ready=0 for 100 cycles required 1");
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tag_cnt++;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 0; sign = 0; sat = 0; tag = '0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got %b required 0", in_ready);
        end
        checks++;
        if ({out_valid, s, z, v, n, out_tag} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b s=%h z=%b v=%b n=%b tag=%0d required all 0",
                     out_valid, s, z, v, n, out_tag);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready got %b required 1", in_ready);
        end
        $display("  reset done");
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [5] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [W-1:0] vb [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h1234_5678};
        logic         vs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic         vg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int  lat;
        bit  ok;
        send_op(va[0], vb[0], vs[0], vg[0], 1'b0);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        checks++;
        if (lat != ST || s !== 32'h8000_0000 || v !== 1'b1 || n !== 1'b0 || z !== 1'b0) begin
            failures++;
            $display("FAIL vec_signed_sub latency=%0d s=%h v=%b n=%b z=%b required latency=%0d s=80000000 v=1 n=0 z=0",
                     lat, s, v, n, z, ST);
        end
        @(posedge clk); #1;
        for (int i = 1; i < 5; i++) send_op(va[i], vb[i], vs[i], vg[i], 1'b0);
        wait_idle(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL vectors_drain got pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] t0;
        bit ok;
        t0 = tag_cnt;
        send_op(32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
        send_op(32'd3, 32'd7, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
        end
        checks++;
        if (s !== 32'd0 || z !== 1'b1 || out_tag !== t0) begin
            failures++;
            $display("FAIL b2b_first got s=%h z=%b tag=%0d required s=0 z=1 tag=%0d", s, z, out_tag, t0);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || s !== 32'd10 || z !== 1'b0 || out_tag !== t0 + 1'b1) begin
            failures++;
            $display("FAIL b2b_second got valid=%b s=%h z=%b tag=%0d required valid=1 s=a z=0 tag=%0d",
                     out_valid, s, z, out_tag, t0 + 1'b1);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) send_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        wait_idle(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_drain got pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_stall();
        logic [W+TW+2:0] snap;
        bit ok, frozen;
        out_ready = 1'b0;
        for (int i = 0; i < ST; i++) send_op(32'h100 + i, 32'h10 * i, 1'(i % 2), 1'b1, 1'b0);
        a = 32'hDEAD_0000; b = 32'h0000_BEEF; sub = 1'b1; sign = 1'b0; sat = 1'b0; tag = tag_cnt;
        in_valid = 1'b1;
        @(negedge clk);
        snap = {s, z, v, n, out_tag};
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_entry got valid=%b in_ready=%b required valid=1 in_ready=0", out_valid, in_ready);
        end
        frozen = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {s, z, v, n, out_tag} !== snap) frozen = 0;
        end
        checks++;
        if (!frozen) begin
            failures++;
            $display("FAIL stall_frozen got s=%h tag=%0d in_ready=%b required s=%h tag=%0d in_ready=0",
                     s, out_tag, in_ready, snap[W+TW+2:TW+3], snap[TW-1:0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_in_ready got %b required 1", in_ready);
        end else begin
            sb.push_back(model(a, b, sub, sign, 1'b0, tag_cnt));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tag_cnt++;
        for (int i = 0; i < ST; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL drain_rate cycle=%0d got out_valid=%b required 1", i, out_valid);
            end
            @(posedge clk); #1;
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_drain got pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset_flush();
        bit quiet = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_op(32'h55 * (i + 1), 32'h3 * i, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, s, z, v, n, out_tag} !== '0) begin
            failures++;
            $display("FAIL flush_outputs got valid=%b s=%h z=%b v=%b n=%b tag=%0d required all 0",
                     out_valid, s, z, v, n, out_tag);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL flush_stale got out_valid=1 after reset required 0");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sat();
`ifdef ALU_ADDER_SAT_EN
        bit ok;
        send_op(32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b0, 1'b1);
        send_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
        end
        checks++;
        if (s !== 32'hFFFF_FFFF || n !== 1'b1) begin
            failures++;
            $display("FAIL sat_unsigned got s=%h n=%b required s=ffffffff n=1", s, n);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (s !== 32'h7FFF_FFFF || v !== 1'b1) begin
            failures++;
            $display("FAIL sat_signed got s=%h v=%b required s=7fffffff v=1", s, v);
        end
        @(posedge clk); #1;
        send_op(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
        send_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
        wait_idle(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL sat_drain got pending=%0d required 0", sb.size());
        end
`else
        $display("  saturation not built");
`endif
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        bit pending = 0;
        bit ok;
        int sent = 0;
        for (int cyc = 0; cyc < 400 && sent < 40; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pending && $urandom_range(0, 4) != 0) begin
                a = pick_operand(); b = pick_operand();
                sub = 1'($urandom_range(0, 1)); sign = 1'($urandom_range(0, 1));
                sat = 1'($urandom_range(0, 1)); tag = tag_cnt;
                in_valid = 1'b1;
                pending = 1;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, sub, sign, sat & SAT_BUILD, tag_cnt));
                pending = 0;
                tag_cnt++;
                sent++;
            end
            @(posedge clk); #1;
            if (!pending) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok || sent < 40) begin
            failures++;
            $display("FAIL random_drain got sent=%0d pending=%0d required sent=40 pending=0", sent, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
